roll_sequencer: RTL and testbench

Roll controller between `Game_FSM` and `Dice_Manager`. It turns a single roll request into a decelerating "tumble" burst of `roll_en` pulses and latches the hold mask for the duration of the roll. It also enforces the per-turn roll budget and reports completion back to the FSM. It replaces the direct `roll_sig` → `roll_en` connection in the top level.

---
 rtl/roll_sequencer.sv | 171 +++++++++++++++++
 tb/tb_roll_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/roll_sequencer.sv
// Roll controller: turns one roll request into a decelerating burst of roll_en pulses,
// latches the hold mask and enforces the per-turn roll budget. Tumble enabled by ROLL_SEQ_ANIM_EN.

module roll_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int STEPS      = 8,
    parameter int BASE_TICKS = 20,
    parameter int MAX_ROLLS  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       roll_req,
    input  logic       turn_start,
    input  logic [4:0] hold_sw,
    output logic       roll_en,
    output logic [4:0] hold_mask,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic [1:0] rolls_left
);

    if (TICK_DIV < 1 || STEPS < 1 || BASE_TICKS < 1 || MAX_ROLLS < 1 || MAX_ROLLS > 3) begin : g_bad_params
        $error("roll_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [1:0] ROLLS_INIT = 2'(MAX_ROLLS);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   refuse;

    // FINISH is not busy, so a request arriving with done high is accepted.
    assign busy    = (state == PULSE) || (state == WAIT);
    assign roll_en = (state == PULSE);
    assign done    = (state == FINISH);

    assign accept = roll_req && !turn_start && !busy && (rolls_left != 2'd0);
    assign refuse = roll_req && !turn_start && (busy || (rolls_left == 2'd0));

`ifdef ROLL_SEQ_ANIM_EN
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IVL_W  = $clog2(BASE_TICKS * STEPS + 1);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_next;
    logic [IVL_W-1:0]  ticks;
    logic [IVL_W-1:0]  ticks_next;
    logic [IVL_W-1:0]  ticks_eff;
    logic [PRE_W-1:0]  presc;
    logic [PRE_W-1:0]  presc_next;
    logic [PRE_W-1:0]  presc_eff;
    logic              tick;
    logic              interval_end;
    logic              last_step;

    // The PULSE cycle is the first cycle of the interval, so the counters read as
    // zero there; this keeps pulse-to-pulse spacing exactly TICK_DIV*BASE_TICKS*(k+1).
    always_comb begin
        presc_eff    = (state == PULSE) ? '0 : presc;
        ticks_eff    = (state == PULSE) ? '0 : ticks;
        tick         = (int'(presc_eff) == TICK_DIV - 1);
        interval_end = tick && (int'(ticks_eff) + 1 == BASE_TICKS * (int'(step) + 1));
        last_step    = (int'(step) == STEPS - 1);
    end

    // NOTE: every variable gets its default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        step_next  = step;
        presc_next = presc;
        ticks_next = ticks;
        case (state)
            IDLE, FINISH: begin
                if (accept) begin
                    state_next = PULSE;
                    step_next  = '0;
                    presc_next = '0;
                    ticks_next = '0;
                end else if (state == FINISH) begin
                    state_next = IDLE;
                end
            end
            PULSE, WAIT: begin
                presc_next = tick ? '0 : presc_eff + 1'b1;
                ticks_next = tick ? ticks_eff + 1'b1 : ticks_eff;
                if (interval_end) begin
                    if (last_step) begin
                        state_next = FINISH;
                    end else begin
                        state_next = PULSE;
                        step_next  = step + 1'b1;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
        if (turn_start) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step  <= '0;
            presc <= '0;
            ticks <= '0;
        end else begin
            step  <= step_next;
            presc <= presc_next;
            ticks <= ticks_next;
        end
    end
`else
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH: begin
                if (accept) begin
                    state_next = PULSE;
                end else if (state == FINISH) begin
                    state_next = IDLE;
                end
            end
            PULSE:   state_next = FINISH;
            default: state_next = IDLE;
        endcase
        if (turn_start) begin
            state_next = IDLE;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Budget, hold mask and reject: turn_start behaves exactly like reset here.
    always_ff @(posedge clk) begin
        if (!reset_n || turn_start) begin
            rolls_left <= ROLLS_INIT;
            hold_mask  <= '0;
            reject     <= 1'b0;
        end else begin
            reject <= refuse;
            if (accept) begin
                rolls_left <= rolls_left - 1'b1;
                hold_mask  <= (rolls_left == ROLLS_INIT) ? 5'b0 : hold_sw;
            end
        end
    end

endmodule

// File: tb/tb_roll_sequencer.sv
// Self-checking bench for roll_sequencer: directed scenarios plus random traffic,
// compared every cycle against a schedule-based reference model.

module tb_roll_sequencer;

    localparam int TD = 2;
    localparam int ST = 3;
    localparam int BT = 1;
    localparam int MR = 3;
`ifdef ROLL_SEQ_ANIM_EN
    localparam int T_DONE = TD * BT * ST * (ST + 1) / 2;
`else
    localparam int T_DONE = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       roll_req;
    logic       turn_start;
    logic [4:0] hold_sw;
    logic       roll_en;
    logic [4:0] hold_mask;
    logic       busy;
    logic       done;
    logic       reject;
    logic [1:0] rolls_left;

    always #5 clk = ~clk;

    roll_sequencer #(
        .TICK_DIV  (TD),
        .STEPS     (ST),
        .BASE_TICKS(BT),
        .MAX_ROLLS (MR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .roll_req  (roll_req),
        .turn_start(turn_start),
        .hold_sw   (hold_sw),
        .roll_en   (roll_en),
        .hold_mask (hold_mask),
        .busy      (busy),
        .done      (done),
        .reject    (reject),
        .rolls_left(rolls_left)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model: edge at which the current roll was accepted (-1 = none),
    // from which the whole pulse/done/busy schedule follows arithmetically.
    int         acc      = -1;
    int         m_rolls  = MR;
    logic [4:0] m_mask   = 5'b0;
    logic       m_reject = 1'b0;

    function automatic bit is_pulse(int off);
`ifdef ROLL_SEQ_ANIM_EN
        for (int k = 0; k < ST; k++) begin
            if (off == TD * BT * k * (k + 1) / 2) return 1'b1;
        end
        return 1'b0;
`else
        return off == 0;
`endif
    endfunction

    function automatic bit busy_at(int x);
        return acc >= 0 && x >= acc && x < acc + T_DONE;
    endfunction

    function automatic bit pulse_at(int x);
        return busy_at(x) && is_pulse(x - acc);
    endfunction

    function automatic bit done_at(int x);
        return acc >= 0 && x == acc + T_DONE;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        int e;
        @(posedge clk);
        e = edge_n;
        if (!reset_n || turn_start) begin
            acc      = -1;
            m_rolls  = MR;
            m_mask   = 5'b0;
            m_reject = 1'b0;
        end else if (roll_req) begin
            if (busy_at(e - 1) || m_rolls == 0) begin
                m_reject = 1'b1;
            end else begin
                m_reject = 1'b0;
                m_mask   = (m_rolls == MR) ? 5'b0 : hold_sw;
                m_rolls  = m_rolls - 1;
                acc      = e;
            end
        end else begin
            m_reject = 1'b0;
        end
        #1;
        check("roll_en",    {4'b0, roll_en}, {4'b0, pulse_at(e)});
        check("busy",       {4'b0, busy},    {4'b0, busy_at(e)});
        check("done",       {4'b0, done},    {4'b0, done_at(e)});
        check("reject",     {4'b0, reject},  {4'b0, m_reject});
        check("hold_mask",  hold_mask,       m_mask);
        check("rolls_left", {3'b0, rolls_left}, 5'(m_rolls));
        edge_n++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            hold_sw = 5'($urandom);
            tick();
        end
    endtask

    task automatic req(input logic [4:0] hs);
        roll_req = 1'b1;
        hold_sw  = hs;
        tick();
        roll_req = 1'b0;
    endtask

    task automatic new_turn();
        turn_start = 1'b1;
        tick();
        turn_start = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        roll_req   = 1'b0;
        turn_start = 1'b0;
        hold_sw    = 5'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // First roll of a turn: no holds, full pulse schedule, budget 3 -> 2.
        new_turn();
        req(5'b10101);
        run(T_DONE + 2);

        // Second roll: mask latched, hold_sw churns during the tumble.
        req(5'b10101);
        run(T_DONE + 2);

        // Third roll uses up the budget, fourth is refused.
        req(5'b01011);
        run(T_DONE + 2);
        req(5'b11111);
        run(3);

        // Request four cycles into a running sequence is refused, schedule intact.
        new_turn();
        req(5'b01110);
        run(3);
        req(5'b11111);
        run(T_DONE + 2);

        // turn_start aborts a running sequence.
        new_turn();
        req(5'b00011);
        req(5'b00101);
        run(3);
        new_turn();
        run(T_DONE + 2);

        // turn_start and roll_req together: the request is dropped silently.
        turn_start = 1'b1;
        roll_req   = 1'b1;
        tick();
        turn_start = 1'b0;
        roll_req   = 1'b0;
        run(3);

        // Reset in the middle of a sequence.
        req(5'b11000);
        req(5'b10001);
        run(2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run(T_DONE + 2);

        // Random traffic.
        repeat (600) begin
            roll_req   = ($urandom % 5) == 0;
            turn_start = ($urandom % 40) == 0;
            reset_n    = ($urandom % 120) != 0;
            hold_sw    = 5'($urandom);
            tick();
        end
        roll_req   = 1'b0;
        turn_start = 1'b0;
        reset_n    = 1'b1;
        run(T_DONE + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
